multicycle_main_fsm: RTL and testbench

// - Main control FSM of the multi-cycle RV32I core; sequences the flopenr-based CurrPC/OldPC/Instr

---
 rtl/multicycle_main_fsm_pkg.sv | 66 ++++++
 rtl/multicycle_main_fsm_if.sv | 33 +++
 rtl/multicycle_main_fsm_decode.sv | 80 ++++++++
 rtl/multicycle_main_fsm.sv | 81 ++++++++
 tb/tb_multicycle_main_fsm.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM:
// state codes, opcodes, datapath mux encodings and the decoded control vector.
package multicycle_main_fsm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] ALU_ADD       = 2'b00;
    localparam logic [1:0] ALU_SUB       = 2'b01;
    localparam logic [1:0] ALU_FUNCT     = 2'b10;

    // Strobes marked *_on_ready only fire in the cycle the memory completes.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_update;
        logic       fetch_on_ready;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       retire;
        logic       retire_on_ready;
    } ctrl_t;

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control/status bundle between the main FSM (master) and the multi-cycle datapath (slave).
interface multicycle_main_fsm_if;
    import multicycle_main_fsm_pkg::*;

    logic [6:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_write;
    logic               adr_src;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               illegal_op;
    logic               retire;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, alu_op, illegal_op, retire, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, alu_op, illegal_op, retire, state_dbg
    );

endinterface

// File: rtl/multicycle_main_fsm_decode.sv
// Moore output decode: maps the current FSM state to the raw datapath control vector.
// Undefined encodings fall through to an all-zero vector so no strobe can fire.
module multicycle_main_fsm_decode
    import multicycle_main_fsm_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src        = ADR_PC;
                ctrl.alu_src_a      = SRCA_PC;
                ctrl.alu_src_b      = SRCB_FOUR;
                ctrl.alu_op         = ALU_ADD;
                ctrl.result_src     = RES_ALURESULT;
                ctrl.fetch_on_ready = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = ADR_RESULT;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src         = ADR_RESULT;
                ctrl.result_src      = RES_ALUOUT;
                ctrl.mem_write       = 1'b1;
                ctrl.retire_on_ready = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: state register, next-state logic,
// and the memory-ready / zero-flag / reset gating of the decoded strobes.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
)
(
    input  logic                 clk,
    input  logic                 resetn,
    multicycle_main_fsm_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   illegal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_main_fsm_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Unknown opcodes retire as a NOP straight out of DECODE.
    assign illegal = (state_q == S_DECODE) && !is_known_op(bus.op);

    // Strobes are forced low while reset is held, even though FETCH would otherwise drive them.
    assign bus.ir_write   = resetn & ctrl.fetch_on_ready & bus.mem_ready;
    assign bus.pc_write   = resetn & (ctrl.pc_update
                                      | (ctrl.fetch_on_ready & bus.mem_ready)
                                      | (ctrl.branch & bus.zero));
    assign bus.reg_write  = resetn & ctrl.reg_write;
    assign bus.mem_write  = resetn & ctrl.mem_write;
    assign bus.illegal_op = resetn & illegal;
    assign bus.retire     = resetn & (ctrl.retire
                                      | (ctrl.retire_on_ready & bus.mem_ready)
                                      | illegal);

    assign bus.adr_src    = ctrl.adr_src;
    assign bus.result_src = ctrl.result_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for the main control FSM: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares state, strobes and the relevant mux selects.
module tb_multicycle_main_fsm;

    localparam logic [3:0] ST_F   = 4'd0;
    localparam logic [3:0] ST_D   = 4'd1;
    localparam logic [3:0] ST_MA  = 4'd2;
    localparam logic [3:0] ST_MR  = 4'd3;
    localparam logic [3:0] ST_MWB = 4'd4;
    localparam logic [3:0] ST_MW  = 4'd5;
    localparam logic [3:0] ST_XR  = 4'd6;
    localparam logic [3:0] ST_XI  = 4'd7;
    localparam logic [3:0] ST_AWB = 4'd8;
    localparam logic [3:0] ST_BEQ = 4'd9;
    localparam logic [3:0] ST_JAL = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Strobe order: {pc_write, ir_write, reg_write, mem_write, illegal_op, retire}
    localparam logic [5:0] SB_NONE  = 6'b000000;
    localparam logic [5:0] SB_FETCH = 6'b110000;
    localparam logic [5:0] SB_WB    = 6'b001001;
    localparam logic [5:0] SB_RET   = 6'b000001;
    localparam logic [5:0] SB_BR    = 6'b100001;
    localparam logic [5:0] SB_PC    = 6'b100000;
    localparam logic [5:0] SB_MW    = 6'b000100;
    localparam logic [5:0] SB_MWR   = 6'b000101;
    localparam logic [5:0] SB_ILL   = 6'b000011;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [5:0] sb;
        logic [8:0] mux;
        logic [8:0] mask;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   drain_checks = 0;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm #(.RESET_STATE(4'd0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mux order: {adr_src, result_src, alu_src_a, alu_src_b, alu_op}; mask keeps only fields the state defines.
    function automatic logic [17:0] mux_for(input logic [3:0] st);
        case (st)
            ST_F:   return {9'b0_10_00_10_00, 9'b1_11_11_11_11};
            ST_D:   return {9'b0_00_01_01_00, 9'b0_00_11_11_11};
            ST_MA:  return {9'b0_00_10_01_00, 9'b0_00_11_11_11};
            ST_MR:  return {9'b1_00_00_00_00, 9'b1_11_00_00_00};
            ST_MWB: return {9'b0_01_00_00_00, 9'b0_11_00_00_00};
            ST_MW:  return {9'b1_00_00_00_00, 9'b1_11_00_00_00};
            ST_XR:  return {9'b0_00_10_00_10, 9'b0_00_11_11_11};
            ST_XI:  return {9'b0_00_10_01_10, 9'b0_00_11_11_11};
            ST_AWB: return {9'b0_00_00_00_00, 9'b0_11_00_00_00};
            ST_BEQ: return {9'b0_00_10_00_01, 9'b0_11_11_11_11};
            ST_JAL: return {9'b0_00_01_10_00, 9'b0_11_11_11_11};
            default: return '0;
        endcase
    endfunction

    task automatic applyStimulus(input string name, input logic rstn, input logic [6:0] op_in,
                                 input logic zero_in, input logic ready_in,
                                 input logic [3:0] st, input logic [5:0] sb);
        exp_t        e;
        logic [17:0] mm;
        resetn        = rstn;
        bus.op        = op_in;
        bus.zero      = zero_in;
        bus.mem_ready = ready_in;
        mm     = mux_for(st);
        e.name = name;
        e.st   = st;
        e.sb   = sb;
        e.mux  = mm[17:9];
        e.mask = mm[8:0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] sb;
        logic [8:0] mx;
        sb = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.illegal_op, bus.retire};
        mx = {bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
        check_count++;
        if (bus.state_dbg === e.st && sb === e.sb && (mx & e.mask) === (e.mux & e.mask)) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got state=%0d strobes=%b mux=%b, expected state=%0d strobes=%b mux=%b (mask %b)",
                     e.name, bus.state_dbg, sb, mx, e.st, e.sb, e.mux, e.mask);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        resetn        = 1'b0;
        bus.op        = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("reset_hold0", 1'b0, OP_LW, 1'b0, 1'b1, ST_F, SB_NONE);
        applyStimulus("reset_hold1", 1'b0, OP_LW, 1'b0, 1'b1, ST_F, SB_NONE);

        applyStimulus("lw_fetch",   1'b1, OP_LW, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("lw_decode",  1'b1, OP_LW, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("lw_memadr",  1'b1, OP_LW, 1'b0, 1'b1, ST_MA,  SB_NONE);
        applyStimulus("lw_memread", 1'b1, OP_LW, 1'b0, 1'b1, ST_MR,  SB_NONE);
        applyStimulus("lw_memwb",   1'b1, OP_LW, 1'b0, 1'b1, ST_MWB, SB_WB);

        applyStimulus("sw_fetch",   1'b1, OP_SW, 1'b0, 1'b1, ST_F,  SB_FETCH);
        applyStimulus("sw_decode",  1'b1, OP_SW, 1'b0, 1'b1, ST_D,  SB_NONE);
        applyStimulus("sw_memadr",  1'b1, OP_SW, 1'b0, 1'b1, ST_MA, SB_NONE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("sw_wait%0d", i), 1'b1, OP_SW, 1'b0, 1'b0, ST_MW, SB_MW);
        end
        applyStimulus("sw_ready",   1'b1, OP_SW, 1'b0, 1'b1, ST_MW, SB_MWR);

        applyStimulus("beq1_fetch",  1'b1, OP_B, 1'b1, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("beq1_decode", 1'b1, OP_B, 1'b1, 1'b1, ST_D,   SB_NONE);
        applyStimulus("beq1_taken",  1'b1, OP_B, 1'b1, 1'b1, ST_BEQ, SB_BR);
        applyStimulus("beq0_fetch",  1'b1, OP_B, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("beq0_decode", 1'b1, OP_B, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("beq0_nottkn", 1'b1, OP_B, 1'b0, 1'b1, ST_BEQ, SB_RET);

        applyStimulus("jal_fetch",  1'b1, OP_J, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("jal_decode", 1'b1, OP_J, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("jal_jal",    1'b1, OP_J, 1'b0, 1'b1, ST_JAL, SB_PC);
        applyStimulus("jal_aluwb",  1'b1, OP_J, 1'b0, 1'b1, ST_AWB, SB_WB);

        applyStimulus("r_fetch",  1'b1, OP_R, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("r_decode", 1'b1, OP_R, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("r_execr",  1'b1, OP_R, 1'b0, 1'b1, ST_XR,  SB_NONE);
        applyStimulus("r_aluwb",  1'b1, OP_R, 1'b0, 1'b1, ST_AWB, SB_WB);
        applyStimulus("i_fetch",  1'b1, OP_I, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("i_decode", 1'b1, OP_I, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("i_execi",  1'b1, OP_I, 1'b0, 1'b1, ST_XI,  SB_NONE);
        applyStimulus("i_aluwb",  1'b1, OP_I, 1'b0, 1'b1, ST_AWB, SB_WB);

        applyStimulus("ill_fetch",  1'b1, OP_BAD, 1'b0, 1'b1, ST_F, SB_FETCH);
        applyStimulus("ill_decode", 1'b1, OP_BAD, 1'b0, 1'b1, ST_D, SB_ILL);

        applyStimulus("stall_fetch0", 1'b1, OP_R, 1'b0, 1'b0, ST_F,   SB_NONE);
        applyStimulus("stall_fetch1", 1'b1, OP_R, 1'b0, 1'b0, ST_F,   SB_NONE);
        applyStimulus("stall_ready",  1'b1, OP_R, 1'b0, 1'b1, ST_F,   SB_FETCH);
        applyStimulus("stall_decode", 1'b1, OP_R, 1'b0, 1'b1, ST_D,   SB_NONE);
        applyStimulus("stall_execr",  1'b1, OP_R, 1'b0, 1'b1, ST_XR,  SB_NONE);
        applyStimulus("stall_aluwb",  1'b1, OP_R, 1'b0, 1'b1, ST_AWB, SB_WB);

        applyStimulus("rst_fetch",   1'b1, OP_LW, 1'b0, 1'b1, ST_F,  SB_FETCH);
        applyStimulus("rst_decode",  1'b1, OP_LW, 1'b0, 1'b1, ST_D,  SB_NONE);
        applyStimulus("rst_memadr",  1'b1, OP_LW, 1'b0, 1'b1, ST_MA, SB_NONE);
        applyStimulus("rst_memread", 1'b1, OP_LW, 1'b0, 1'b0, ST_MR, SB_NONE);
        applyStimulus("rst_abort0",  1'b0, OP_LW, 1'b0, 1'b1, ST_F,  SB_NONE);
        applyStimulus("rst_abort1",  1'b0, OP_LW, 1'b0, 1'b1, ST_F,  SB_NONE);
        applyStimulus("rst_refetch", 1'b1, OP_LW, 1'b0, 1'b1, ST_F,  SB_FETCH);
        applyStimulus("rst_redecode", 1'b1, OP_LW, 1'b0, 1'b1, ST_D, SB_NONE);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            drain_checks++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count + drain_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
